// File: rtl/nios2_cpu_update_pkg.sv
// Shared definitions for the Nios II update bank.
// Contents: register address map, CTRL/STATUS bit positions and the
// commit FSM state type. Imported by the top and the commit FSM.
package nios2_cpu_update_pkg;

  // Word address map
  localparam logic [3:0] SHADOW_BASE = 4'h0;
  localparam logic [3:0] CTRL_ADDR   = 4'h8;
  localparam logic [3:0] STATUS_ADDR = 4'h9;
  localparam logic [3:0] ACTIVE_ADDR = 4'hA;

  // CTRL bit positions
  localparam int CTRL_COMMIT_BIT = 0;
  localparam int CTRL_AUTO_BIT   = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;
  localparam int CTRL_SEL_LSB    = 4;
  localparam int CTRL_SEL_MSB    = 6;

  // STATUS bit positions
  localparam int STATUS_PENDING_BIT = 0;
  localparam int STATUS_BUSY_BIT    = 1;
  localparam int STATUS_OVERRUN_BIT = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/nios2_cpu_update_commit_fsm.sv
// Commit sequencer for the update bank.
// Owns the pending-commit flag, the IDLE/VALID state, out_valid, the
// bank load strobe and the sticky overrun flag.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   commit_set_i      a commit request arrives at this edge
//   out_ready_i       downstream accepts the active bank
//   overrun_w1c_i     clear the sticky overrun flag at this edge
//   load_o            copy shadow bank into the active bank at this edge
//   commit_req_o      a commit is waiting to be loaded
//   out_valid_o       active bank holds an unacknowledged update
//   overrun_o         sticky: a commit was lost
module nios2_cpu_update_commit_fsm
  import nios2_cpu_update_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic commit_set_i,
  input  logic out_ready_i,
  input  logic overrun_w1c_i,
  output logic load_o,
  output logic commit_req_o,
  output logic out_valid_o,
  output logic overrun_o
);

  fsm_state_e state_q, state_d;
  logic       commit_req_q, commit_req_d;
  logic       out_valid_q, out_valid_d;
  logic       overrun_q, overrun_d;
  logic       handshake;
  logic       load;

  assign handshake = out_valid_q & out_ready_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      commit_req_q <= 1'b0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      commit_req_q <= commit_req_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    load        = 1'b0;
    case (state_q)
      IDLE: begin
        if (commit_req_q) begin
          load        = 1'b1;
          out_valid_d = 1'b1;
          state_d     = VALID;
        end
      end
      VALID: begin
        if (handshake) begin
          if (commit_req_q) begin
            // Back-to-back update: reload while keeping out_valid high.
            load = 1'b1;
          end else begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A new request at the same edge as a consume wins, so it is not lost.
    if (commit_set_i) begin
      commit_req_d = 1'b1;
    end else if (load) begin
      commit_req_d = 1'b0;
    end else begin
      commit_req_d = commit_req_q;
    end

    // A request landing on an unconsumed one merges into it; flag the loss.
    // A new loss beats a clear at the same edge.
    overrun_d = (commit_set_i & commit_req_q & ~load) |
                (overrun_q & ~overrun_w1c_i);
  end

  assign load_o       = load;
  assign commit_req_o = commit_req_q;
  assign out_valid_o  = out_valid_q;
  assign overrun_o    = overrun_q;

endmodule

// File: rtl/nios2_cpu_update_bank.sv
// Multi-channel update-value register bank on the Nios II Avalon-MM bus.
// CPU writes CHANNELS shadow registers, then commits; the whole shadow
// bank is copied atomically into the active bank presented on out_port
// with a valid/ready handshake.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   address, chipselect,
//   write_n, writedata      Avalon-MM slave write side
//   readdata                combinational read data, zero wait states
//   out_port                active bank, channel i at [i*WIDTH +: WIDTH]
//   out_valid, out_ready    downstream handshake
//   irq                     overrun & IRQ_EN
module nios2_cpu_update_bank
  import nios2_cpu_update_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               CHANNELS    = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic [CHANNELS*WIDTH-1:0] out_port,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      irq
);

  localparam logic [3:0] CHAN_LIMIT = 4'(CHANNELS);

  logic [WIDTH-1:0] shadow_q [CHANNELS];
  logic [WIDTH-1:0] shadow_d [CHANNELS];
  logic [WIDTH-1:0] active_q [CHANNELS];
  logic [WIDTH-1:0] active_d [CHANNELS];
  logic             auto_q, auto_d;
  logic             irq_en_q, irq_en_d;
  logic [2:0]       sel_q, sel_d;

  logic wr_en;
  logic shadow_wr;
  logic ctrl_wr;
  logic status_wr;
  logic commit_set;
  logic overrun_w1c;
  logic load;
  logic commit_req;
  logic overrun;

  assign wr_en       = chipselect & ~write_n;
  // Shadow slots beyond CHANNELS are holes: no store, no auto-commit.
  assign shadow_wr   = wr_en & ((address - SHADOW_BASE) < CHAN_LIMIT);
  assign ctrl_wr     = wr_en & (address == CTRL_ADDR);
  assign status_wr   = wr_en & (address == STATUS_ADDR);
  assign commit_set  = (ctrl_wr & writedata[CTRL_COMMIT_BIT]) | (shadow_wr & auto_q);
  assign overrun_w1c = status_wr & writedata[STATUS_OVERRUN_BIT];

  nios2_cpu_update_commit_fsm u_commit_fsm (
    .clk           (clk),
    .reset         (reset),
    .commit_set_i  (commit_set),
    .out_ready_i   (out_ready),
    .overrun_w1c_i (overrun_w1c),
    .load_o        (load),
    .commit_req_o  (commit_req),
    .out_valid_o   (out_valid),
    .overrun_o     (overrun)
  );

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    auto_d   = auto_q;
    irq_en_d = irq_en_q;
    sel_d    = sel_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (shadow_wr && (address == SHADOW_BASE + 4'(i))) begin
        shadow_d[i] = writedata[WIDTH-1:0];
      end
      // Load takes the shadow as it stood before this edge's write.
      if (load) begin
        active_d[i] = shadow_q[i];
      end
    end
    if (ctrl_wr) begin
      auto_d   = writedata[CTRL_AUTO_BIT];
      irq_en_d = writedata[CTRL_IRQ_EN_BIT];
      sel_d    = writedata[CTRL_SEL_MSB:CTRL_SEL_LSB];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= RESET_VALUE;
        active_q[i] <= RESET_VALUE;
      end
      auto_q   <= 1'b0;
      irq_en_q <= 1'b0;
      sel_q    <= 3'd0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      auto_q   <= auto_d;
      irq_en_q <= irq_en_d;
      sel_q    <= sel_d;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_out
    assign out_port[gi*WIDTH +: WIDTH] = active_q[gi];
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      CTRL_ADDR: begin
        readdata[CTRL_AUTO_BIT]               = auto_q;
        readdata[CTRL_IRQ_EN_BIT]             = irq_en_q;
        readdata[CTRL_SEL_MSB:CTRL_SEL_LSB]   = sel_q;
      end
      STATUS_ADDR: begin
        readdata[STATUS_PENDING_BIT] = commit_req;
        readdata[STATUS_BUSY_BIT]    = out_valid;
        readdata[STATUS_OVERRUN_BIT] = overrun;
      end
      ACTIVE_ADDR: begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (sel_q == 3'(i)) readdata = 32'(active_q[i]);
        end
      end
      default: begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (address == SHADOW_BASE + 4'(i)) readdata = 32'(shadow_q[i]);
        end
      end
    endcase
  end

  assign irq = overrun & irq_en_q;

  // Upper writedata bits are meaningless for narrow channels.
  logic unused_writedata;
  assign unused_writedata = ^writedata;

endmodule
